// File: rtl/down_counter_nbit.sv
`default_nettype none
// ============================================================================
// Module  : down_counter_nbit
// Purpose : Loadable down counter with registered terminal-count pulse.
//           Optional build macro: DOWN_CNT_AUTORELOAD_EN (reload on expiry).
// Revision: 1.0 - initial release
// ============================================================================
module down_counter_nbit #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic             dec,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] out,
  output logic             borrow,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] C_ONE = WIDTH'(1);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;

`ifdef DOWN_CNT_AUTORELOAD_EN
  logic [WIDTH-1:0] r_rld, w_rld_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_rld <= '0;
    else       r_rld <= w_rld_nxt;
  end

  always_comb begin
    w_rld_nxt = r_rld;
    if (ld) w_rld_nxt = data;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_done  <= w_done_nxt;
    end
  end

  // Load wins over everything; done is a pulse, so it defaults low every cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_done_nxt  = 1'b0;
    if (ld) begin
      w_state_nxt = S_RUN;
      w_cnt_nxt   = data;
    end else begin
      case (r_state)
        S_RUN: begin
          if (dec) begin
            if (r_cnt != '0) begin
              w_cnt_nxt = r_cnt - C_ONE;
            end else begin
              w_done_nxt = 1'b1;
`ifdef DOWN_CNT_AUTORELOAD_EN
              w_cnt_nxt  = r_rld;
`else
              w_state_nxt = S_DONE;
`endif
            end
          end
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  assign out    = r_cnt;
  assign borrow = (r_cnt == '0);
  assign done   = r_done;
  assign busy   = (r_state == S_RUN);

endmodule
`default_nettype wire

// File: doc/down_counter_nbit.md
# down_counter_nbit

Loadable down counter with terminal-count detection. The complement of the team's 3-bit up counter: `ld` presets the count, `dec` steps it toward zero, and a registered `done` pulse reports expiry. Datapath controllers use it as the consumer side of a counted loop, for example draining N items or timing N steps, where the up counter is the producer side.

## Interface
- `WIDTH`, default 3: counter, data and reload-register width in bits.

Ports:
- `clk`  input  1: rising-edge clock; the only clock.
- `reset`  input  1: synchronous, active-high; overrides all other inputs.
- `ld`  input  1: load `data` into the count and reload registers; start a run.
- `dec`  input  1: decrement enable; honoured only in RUN.
- `data`  input  WIDTH: preset value, sampled when `ld` is high.
- `out`  output  WIDTH: current count, registered.
- `borrow`  output  1: combinational, 1 when `out == 0`.
- `done`  output  1: registered one-cycle terminal-count pulse.
- `busy`  output  1: 1 while the FSM is in RUN; decoded from the state register only.

## Operation
- Internal state:
  - FSM with states IDLE, RUN, DONE.
  - Reload register `rld` of WIDTH bits.
- Priority at each rising edge of `clk`: `reset` > `ld` > `dec`.
- `reset`:
  - `out = 0`, `rld = 0`, `done = 0`, state IDLE.
  - Outputs after reset: `borrow = 1`, `busy = 0`.
- `ld`, in any state:
  - `out <= data`, `rld <= data`, state goes to RUN, `done <= 0`.
  - Any concurrent `dec` is ignored.
- RUN, `dec = 1`, `out != 0`: `out <= out - 1`; state stays RUN.
- RUN, `dec = 1`, `out == 0` (terminal decrement):
  - `done <= 1` for exactly one cycle.
  - Behaviour of `out` and the next state depends on `DOWN_CNT_AUTORELOAD_EN` (see Configuration).
- RUN, `dec = 0`: hold.
- IDLE: `dec` is ignored; `out` holds.
- DONE:
  - `dec` is ignored.
  - Unconditional transition to IDLE on the next edge, unless `ld` is high.
- Arithmetic: modulo-2^WIDTH subtraction is never exercised. `out` never decrements below 0.
- `ld` with `data = 0` is legal:
  - The FSM enters RUN with `borrow = 1`.
  - The next `dec` is the terminal decrement.
- `done` is 0 in every cycle other than the one following a terminal decrement.

## Timing
- `out` changes one cycle after the sampling edge of `ld` or `dec`.
- `borrow` follows `out` combinationally, in the same cycle.
- `done` goes high in the cycle after the edge that performs the terminal decrement and falls at the following edge.
  - This holds even if `ld` arrives on that edge. `ld` has priority, and its load clears `done`.
- Preset of N with `dec` held high continuously: the terminal decrement occurs at the (N+1)th edge after the load.
- `busy` falls in the same cycle `done` rises (non-autoreload build).
- Reset mid-run: the next edge forces IDLE, `out = 0` and `done = 0`. A pending `done` is discarded.

## Configuration
- Macro `DOWN_CNT_AUTORELOAD_EN`.
- Defined:
  - Terminal decrement does `out <= rld`, pulses `done`, and the state stays RUN.
  - DONE is unreachable; `busy` stays 1 until `reset`.
  - Reload value 0 gives `done` on every `dec` cycle.
- Undefined:
  - Terminal decrement leaves `out = 0`, pulses `done`, and moves to DONE, then IDLE.
  - `rld` may be kept for readback but does not affect behaviour.

## Test plan
- Reset, then hold `dec = 1` with no load:
  - Expect `out = 0`, `borrow = 1`, `busy = 0` and `done = 0` for 10 cycles.
- `ld` with `data = 3`, then `dec` held high:
  - `out` sequence 3, 2, 1, 0.
  - `done = 1` for exactly one cycle after the 4th `dec` edge.
  - `busy` falls in that same cycle; `out` stays 0 afterwards.
- `ld` with `data = 5`, then `dec` toggled 1/0:
  - `out` steps only on `dec = 1` cycles: 5, 4, 4, 3, …
- `ld` and `dec` both high with `data = 6` while `out = 2`:
  - `out = 6` next cycle, with no decrement.
- Load 7, then assert `reset` when `out = 4`:
  - Next cycle `out = 0`, `busy = 0` and `done = 0`.
  - No `done` appears later.
- With `DOWN_CNT_AUTORELOAD_EN` defined, `ld` with `data = 2` and `dec` held high:
  - `out` sequence 2, 1, 0, 2, 1, 0.
  - `done` pulses every 3 cycles; `busy` is always 1.
